// File: rtl/adder_arb.sv
// Round-robin arbiter that shares one combinational adder between NUM_REQ requesters.
// Optional ADDER_ARB_STATS_EN adds stat_cnt_o, a saturating count of consumed responses.
module adder_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                                main_clk_i,
    input  logic                                main_rst_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b_i,
    output logic [DATA_WIDTH-1:0]               add_a_o,
    output logic [DATA_WIDTH-1:0]               add_b_o,
    input  logic [DATA_WIDTH:0]                 add_x_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [ID_WIDTH-1:0]                 rsp_id_o,
`ifdef ADDER_ARB_STATS_EN
    output logic [15:0]                         stat_cnt_o,
`endif
    output logic [DATA_WIDTH:0]                 rsp_sum_o
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_r;
    logic [ID_WIDTH-1:0]    ptr_r;
    logic [ID_WIDTH-1:0]    id_r;
    logic [DATA_WIDTH:0]    sum_r;
    logic [ID_WIDTH-1:0]    grant_s;
    logic [ID_WIDTH-1:0]    ptr_nxt_s;
    logic                   win_s;
    logic                   can_acc_s;
    logic                   hs_s;

    // Round-robin search over req_valid_i starting at the pointer, wrapping at NUM_REQ-1
    always_comb begin
        int                  sum_v;
        logic [ID_WIDTH-1:0] idx_v;
        win_s   = 1'b0;
        grant_s = '0;
        sum_v   = 0;
        idx_v   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v = int'(ptr_r) + k;
            if (sum_v >= NUM_REQ) begin
                sum_v = sum_v - NUM_REQ;
            end else begin
                sum_v = sum_v;
            end
            idx_v = ID_WIDTH'(sum_v);
            if (!win_s && req_valid_i[idx_v]) begin
                win_s   = 1'b1;
                grant_s = idx_v;
            end else begin
                win_s   = win_s;
            end
        end
    end

    // Drive the shared adder from the winner's operands, zero when idle
    always_comb begin
        add_a_o = '0;
        add_b_o = '0;
        if (win_s) begin
            add_a_o = req_a_i[grant_s];
            add_b_o = req_b_i[grant_s];
        end else begin
            add_a_o = '0;
            add_b_o = '0;
        end
    end

    // Reset forces ready low so nothing is acknowledged while the register is cleared
    assign can_acc_s = (state_r == EMPTY) || ((state_r == FULL) && rsp_ready_i);
    assign hs_s      = win_s && can_acc_s && !main_rst_i;

    // One-hot grant to the winner when the response slot can take a new sum
    always_comb begin
        req_ready_o = '0;
        if (hs_s) begin
            req_ready_o[grant_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // Pointer moves to the requester after the winner
    always_comb begin
        ptr_nxt_s = '0;
        if (int'(grant_s) == NUM_REQ - 1) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_s + 1'b1;
        end
    end

    // Response FSM: a handshake always (re)loads the slot, a consume without refill empties it
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_r <= EMPTY;
            ptr_r   <= '0;
            sum_r   <= '0;
            id_r    <= '0;
        end else if (hs_s) begin
            state_r <= FULL;
            ptr_r   <= ptr_nxt_s;
            sum_r   <= add_x_i;
            id_r    <= grant_s;
        end else begin
            case (state_r)
                EMPTY:   state_r <= EMPTY;
                FULL:    state_r <= rsp_ready_i ? EMPTY : FULL;
                default: state_r <= EMPTY;
            endcase
        end
    end

    assign rsp_valid_o = (state_r == FULL);
    assign rsp_sum_o   = sum_r;
    assign rsp_id_o    = id_r;

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] stat_r;

    // Saturating count of consumed responses
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            stat_r <= 16'd0;
        end else if (rsp_valid_o && rsp_ready_i && (stat_r != 16'hFFFF)) begin
            stat_r <= stat_r + 16'd1;
        end else begin
            stat_r <= stat_r;
        end
    end

    assign stat_cnt_o = stat_r;
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Scoreboard bench for adder_arb: a cycle-level reference model predicts grants and
// pushes expected responses; an independent monitor pops and compares them.
module tb_adder_arb;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               main_rst_i;
    logic [N-1:0]       req_valid_i;
    logic [N-1:0]       req_ready_o;
    logic [N-1:0][W-1:0] req_a_i;
    logic [N-1:0][W-1:0] req_b_i;
    logic [W-1:0]       add_a_o;
    logic [W-1:0]       add_b_o;
    logic [W:0]         add_x_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [IW-1:0]      rsp_id_o;
    logic [W:0]         rsp_sum_o;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]        stat_cnt_o;
`endif

    always #5 clk = ~clk;

    // the shared adder lives in the environment
    assign add_x_i = {1'b0, add_a_o} + {1'b0, add_b_o};

    adder_arb #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
        .main_clk_i  (clk),
        .main_rst_i  (main_rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .add_a_o     (add_a_o),
        .add_b_o     (add_b_o),
        .add_x_i     (add_x_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
`ifdef ADDER_ARB_STATS_EN
        .stat_cnt_o  (stat_cnt_o),
`endif
        .rsp_sum_o   (rsp_sum_o)
    );

    int total = 0;
    int bad   = 0;

    bit         pend [N];
    logic [W-1:0] pa [N];
    logic [W-1:0] pb [N];
    int         mptr     = 0;
    bit         mfull    = 1'b0;
    bit         known    = 1'b0;
    bit         prev_rst = 1'b0;
    int         stat_exp = 0;
    logic [IW-1:0] qid[$];
    logic [W:0]    qsum[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    function automatic bit pend_any();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r |= pend[i];
        return r;
    endfunction

    // one clock cycle: drive, predict, check combinational outputs, advance the model
    task automatic step(input bit rst, input bit rr);
        bit           found;
        int           g;
        int           idx;
        logic [N-1:0] er;
        @(negedge clk);
        main_rst_i  = rst;
        rsp_ready_i = rr;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = pend[i];
            req_a_i[i]     = pa[i];
            req_b_i[i]     = pb[i];
        end
        #1;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (!found && pend[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        er = '0;
        if (found && !rst && (!mfull || rr)) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready_o), 32'(er));
        chk("add_a", 32'(add_a_o), found ? 32'(pa[g]) : 32'd0);
        chk("add_b", 32'(add_b_o), found ? 32'(pb[g]) : 32'd0);
        if (known) chk("rsp_valid", 32'(rsp_valid_o), 32'(mfull));
        if (rst && prev_rst) begin
            chk("reset_sum", 32'(rsp_sum_o), 32'd0);
            chk("reset_id", 32'(rsp_id_o), 32'd0);
        end
        prev_rst = rst;
        if (rst) begin
            mfull    = 1'b0;
            mptr     = 0;
            stat_exp = 0;
            known    = 1'b1;
            qid.delete();
            qsum.delete();
        end else if (er != '0) begin
            qid.push_back(IW'(g));
            qsum.push_back({1'b0, pa[g]} + {1'b0, pb[g]});
            mptr    = (g + 1) % N;
            mfull   = 1'b1;
            pend[g] = 1'b0;
        end else if (mfull && rr) begin
            mfull = 1'b0;
        end
    endtask

    task automatic drain();
        int c = 0;
        while ((pend_any() || mfull) && c < 64) begin
            step(1'b0, 1'b1);
            c++;
        end
        chk("drain_idle", {30'd0, pend_any(), mfull}, 32'd0);
    endtask

    // monitor: whenever a response is presented, compare against the queue head
    always begin
        @(negedge clk);
        #2;
        if (known && !main_rst_i) begin
`ifdef ADDER_ARB_STATS_EN
            chk("stat_cnt", 32'(stat_cnt_o), 32'(stat_exp));
`endif
            if (rsp_valid_o) begin
                if (qid.size() == 0) begin
                    chk("rsp_without_request", 32'(rsp_valid_o), 32'd0);
                end else begin
                    chk("rsp_id", 32'(rsp_id_o), 32'(qid[0]));
                    chk("rsp_sum", 32'(rsp_sum_o), 32'(qsum[0]));
                    if (rsp_ready_i) begin
                        void'(qid.pop_front());
                        void'(qsum.pop_front());
                        if (stat_exp < 65535) stat_exp++;
                    end
                end
            end
        end
    end

    initial begin
        main_rst_i  = 1'b1;
        rsp_ready_i = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pb[i]   = '0;
        end

        // reset with every requester asking; first grant afterwards goes to 0
        for (int i = 0; i < N; i++) load(i, W'($urandom), W'($urandom));
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // continuous round robin with all four valid
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) load(i, W'($urandom), W'($urandom));
            step(1'b0, 1'b1);
        end
        drain();

        // single request and carry cases
        load(2, 8'h05, 8'h07);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        load(1, 8'hFF, 8'h01);
        step(1'b0, 1'b1);
        load(1, 8'hFF, 8'hFF);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        drain();

        // backpressure then release: req 3 granted as the held response is consumed
        load(0, 8'h11, 8'h22);
        step(1'b0, 1'b0);
        load(3, 8'h33, 8'h44);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        drain();

        // random traffic with a reset in the middle
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && ($urandom_range(0, 1) == 1)) load(i, W'($urandom), W'($urandom));
            step(c == 150, $urandom_range(0, 3) != 0);
        end
        drain();
        step(1'b0, 1'b1);
        chk("queue_empty", 32'(qid.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
